// File: rtl/riscv_pipe_core.sv
// riscv_pipe_core: 5-stage RV32I-subset pipeline (add sub and or slt addi lw lb sw sb beq jal).
// Branches resolve in D; E operands forward from M then W; a data-cache miss freezes F..M.
module riscv_pipe_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] ReadData,
  input  logic        dhit,
  output logic [31:0] pc,
  output logic [31:0] ALUOut,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  output logic        MemByte,
  output logic        pc_en
);
  logic [31:0] instr_d, pc_d, imm_d, rd1_d, rd2_d, cmp_a, cmp_b, target_d;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3, alu_ctrl_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d, mem_to_reg_d, mem_write_d, byte_d, alu_src_d, beq_d, jal_d;
  logic        use_rs1, use_rs2, taken, lu_hazard, br_hazard, stall, miss;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, byte_e, alu_src_e, jal_e;
  logic [2:0]  alu_ctrl_e;
  logic [4:0]  rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [31:0] rd1_e, rd2_e, imm_e, pc4_e, src_a, src_b, op_b, alu_y, result_e;
  logic        reg_write_m, mem_to_reg_m, reg_write_w;
  logic [7:0]  lb_byte;
  logic [31:0] load_val, result_w;
  logic [31:0] regs [1:31];

  // Main and ALU decoder; unknown encodings leave every write enable low
  always_comb begin
    opcode = instr_d[6:0];
    funct3 = instr_d[14:12];
    funct7 = instr_d[31:25];
    rs1_d = instr_d[19:15];
    rs2_d = instr_d[24:20];
    rd_d = instr_d[11:7];
    reg_write_d = 1'b0; mem_to_reg_d = 1'b0; mem_write_d = 1'b0; byte_d = 1'b0;
    alu_src_d = 1'b0; beq_d = 1'b0; jal_d = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    alu_ctrl_d = 3'b000;
    imm_d = {{20{instr_d[31]}}, instr_d[31:20]};
    case (opcode)
      7'b0110011: begin
        reg_write_d = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: alu_ctrl_d = 3'b000;
          10'b0100000_000: alu_ctrl_d = 3'b001;
          10'b0000000_111: alu_ctrl_d = 3'b010;
          10'b0000000_110: alu_ctrl_d = 3'b011;
          10'b0000000_010: alu_ctrl_d = 3'b101;
          default: begin reg_write_d = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; end
        endcase
      end
      7'b0010011: if (funct3 == 3'b000) begin
        reg_write_d = 1'b1; alu_src_d = 1'b1; use_rs1 = 1'b1;
      end else begin
        reg_write_d = 1'b0;
      end
      7'b0000011: if (funct3 == 3'b010 || funct3 == 3'b000) begin
        reg_write_d = 1'b1; mem_to_reg_d = 1'b1; alu_src_d = 1'b1; use_rs1 = 1'b1;
        byte_d = (funct3 == 3'b000);
      end else begin
        reg_write_d = 1'b0;
      end
      7'b0100011: if (funct3 == 3'b010 || funct3 == 3'b000) begin
        mem_write_d = 1'b1; alu_src_d = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        byte_d = (funct3 == 3'b000);
        imm_d = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      end else begin
        mem_write_d = 1'b0;
      end
      7'b1100011: if (funct3 == 3'b000) begin
        beq_d = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm_d = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      end else begin
        beq_d = 1'b0;
      end
      7'b1101111: begin
        reg_write_d = 1'b1; jal_d = 1'b1;
        imm_d = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      end
      default: reg_write_d = 1'b0;
    endcase
  end

  // Register read with write-through from W, then M-only forwarding for the branch comparator
  always_comb begin
    if (rs1_d == 5'd0) rd1_d = 32'd0;
    else if (reg_write_w && rd_w == rs1_d) rd1_d = result_w;
    else rd1_d = regs[rs1_d];
    if (rs2_d == 5'd0) rd2_d = 32'd0;
    else if (reg_write_w && rd_w == rs2_d) rd2_d = result_w;
    else rd2_d = regs[rs2_d];
    cmp_a = (reg_write_m && rd_m != 5'd0 && rd_m == rs1_d) ? ALUOut : rd1_d;
    cmp_b = (reg_write_m && rd_m != 5'd0 && rd_m == rs2_d) ? ALUOut : rd2_d;
  end

  always_comb begin
    lu_hazard = mem_to_reg_e && (rd_e != 5'd0) &&
                ((use_rs1 && rd_e == rs1_d) || (use_rs2 && rd_e == rs2_d));
    br_hazard = beq_d && ((reg_write_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d)) ||
                          (mem_to_reg_m && rd_m != 5'd0 && (rd_m == rs1_d || rd_m == rs2_d)));
    stall = lu_hazard || br_hazard;
    miss = (MemWrite || mem_to_reg_m) && !dhit;
    pc_en = !(stall || miss);
    taken = !stall && ((beq_d && cmp_a == cmp_b) || jal_d);
    target_d = pc_d + imm_d;
  end

  // Execute: operand forwarding (M over W) and the ALU; jal carries its link value as the result
  always_comb begin
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs1_e) src_a = ALUOut;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs1_e) src_a = result_w;
    else src_a = rd1_e;
    if (reg_write_m && rd_m != 5'd0 && rd_m == rs2_e) src_b = ALUOut;
    else if (reg_write_w && rd_w != 5'd0 && rd_w == rs2_e) src_b = result_w;
    else src_b = rd2_e;
    op_b = alu_src_e ? imm_e : src_b;
    case (alu_ctrl_e)
      3'b000: alu_y = src_a + op_b;
      3'b001: alu_y = src_a - op_b;
      3'b010: alu_y = src_a & op_b;
      3'b011: alu_y = src_a | op_b;
      3'b101: alu_y = ($signed(src_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      default: alu_y = src_a + op_b;
    endcase
    result_e = jal_e ? pc4_e : alu_y;
  end

  always_comb begin
    case (ALUOut[1:0])
      2'd0: lb_byte = ReadData[7:0];
      2'd1: lb_byte = ReadData[15:8];
      2'd2: lb_byte = ReadData[23:16];
      default: lb_byte = ReadData[31:24];
    endcase
    if (MemByte) load_val = {{24{lb_byte[7]}}, lb_byte};
    else load_val = ReadData;
  end

  // Fetch PC and F/D register; a miss outranks the branch flush
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC; instr_d <= 32'd0; pc_d <= 32'd0;
    end else if (pc_en) begin
      pc <= taken ? target_d : pc + 32'd4;
      instr_d <= taken ? 32'd0 : instr;
      pc_d <= taken ? 32'd0 : pc;
    end
  end

  // D/E register; while frozen by a miss it re-captures forwarded operands so W's value is not lost
  always_ff @(posedge clk) begin
    if (reset || (stall && !miss)) begin
      reg_write_e <= 1'b0; mem_to_reg_e <= 1'b0; mem_write_e <= 1'b0; byte_e <= 1'b0;
      alu_src_e <= 1'b0; jal_e <= 1'b0; alu_ctrl_e <= 3'b000;
      rs1_e <= 5'd0; rs2_e <= 5'd0; rd_e <= 5'd0;
      rd1_e <= 32'd0; rd2_e <= 32'd0; imm_e <= 32'd0; pc4_e <= 32'd0;
    end else if (miss) begin
      rd1_e <= src_a; rd2_e <= src_b;
    end else begin
      reg_write_e <= reg_write_d; mem_to_reg_e <= mem_to_reg_d; mem_write_e <= mem_write_d;
      byte_e <= byte_d; alu_src_e <= alu_src_d; jal_e <= jal_d; alu_ctrl_e <= alu_ctrl_d;
      rs1_e <= rs1_d; rs2_e <= rs2_d; rd_e <= rd_d;
      rd1_e <= rd1_d; rd2_e <= rd2_d; imm_e <= imm_d; pc4_e <= pc_d + 32'd4;
    end
  end

  // E/M register (drives the cache port) and M/W register; W takes a bubble during a miss
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUOut <= 32'd0; WriteData <= 32'd0; MemWrite <= 1'b0; MemByte <= 1'b0;
      reg_write_m <= 1'b0; mem_to_reg_m <= 1'b0; rd_m <= 5'd0;
      reg_write_w <= 1'b0; rd_w <= 5'd0; result_w <= 32'd0;
    end else if (miss) begin
      reg_write_w <= 1'b0; rd_w <= 5'd0;
    end else begin
      ALUOut <= result_e;
      WriteData <= byte_e ? {4{src_b[7:0]}} : src_b;
      MemWrite <= mem_write_e; MemByte <= byte_e;
      reg_write_m <= reg_write_e; mem_to_reg_m <= mem_to_reg_e; rd_m <= rd_e;
      reg_write_w <= reg_write_m; rd_w <= rd_m;
      result_w <= mem_to_reg_m ? load_val : ALUOut;
    end
  end

  always_ff @(posedge clk) begin
    if (reg_write_w && rd_w != 5'd0) regs[rd_w] <= result_w;
  end
endmodule

// File: tb/tb_riscv_pipe_core.sv
// Directed bench for riscv_pipe_core: a small program in a model imem; every store it makes is
// checked against a scoreboard queue filled when the program is loaded.
module tb_riscv_pipe_core;
  logic        clk = 1'b0;
  logic        reset, dhit, MemWrite, MemByte, pc_en;
  logic [31:0] instr, ReadData, pc, ALUOut, WriteData;
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        bytew;
  } st_t;
  st_t sb_q[$];
  st_t mon_e;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  riscv_pipe_core dut (
    .clk(clk), .reset(reset), .instr(instr), .ReadData(ReadData), .dhit(dhit),
    .pc(pc), .ALUOut(ALUOut), .WriteData(WriteData), .MemWrite(MemWrite),
    .MemByte(MemByte), .pc_en(pc_en)
  );

  always #5 clk = ~clk;
  assign instr = imem[pc[7:2]];
  assign ReadData = dmem[ALUOut[7:2]];

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  // offsets are passed already halved (bit 0 of a branch/jump offset is always zero)
  function automatic logic [31:0] b_t(input logic [11:0] h, input logic [4:0] rs2, input logic [4:0] rs1);
    return {h[11], h[9:4], rs2, rs1, 3'b000, h[3:0], h[10], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_t(input logic [19:0] h, input logic [4:0] rd);
    return {h[19], h[9:0], h[10], h[18:11], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Store monitor: pops the scoreboard and mirrors the write into the data-memory model
  always @(negedge clk) begin
    if (reset === 1'b0 && MemWrite === 1'b1 && dhit === 1'b1) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL store_extra: got store to %h expected none", ALUOut);
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("st_addr", ALUOut, mon_e.addr);
        check("st_data", WriteData, mon_e.data);
        check("st_byte", {31'd0, MemByte}, {31'd0, mon_e.bytew});
      end
      if (MemByte) dmem[ALUOut[7:2]][ALUOut[1:0]*8 +: 8] = WriteData[7:0];
      else dmem[ALUOut[7:2]] = WriteData;
    end
  end

  initial begin
    logic [31:0] exp_pc [0:8];
    logic        exp_en [0:8];
    logic [31:0] snap_pc, snap_a, snap_d;
    logic        found;
    reset = 1'b1;
    dhit = 1'b1;
    for (int i = 0; i < 64; i++) begin imem[i] = 32'h0000_0013; dmem[i] = 32'd0; end
    dmem[1] = 32'h0000_1234;
    dmem[6] = 32'h0080_0000;
    imem[0]  = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
    imem[1]  = i_t(12'd3, 5'd1, 3'b000, 5'd2, OPI);
    imem[2]  = s_t(12'd0, 5'd2, 5'd0, 3'b010);
    imem[3]  = i_t(12'd4, 5'd0, 3'b010, 5'd3, OPL);
    imem[4]  = r_t(7'd0, 5'd3, 5'd3, 3'b000, 5'd4);
    imem[5]  = s_t(12'd8, 5'd4, 5'd0, 3'b010);
    imem[6]  = i_t(12'hFFF, 5'd0, 3'b000, 5'd7, OPI);
    imem[7]  = i_t(12'd1, 5'd0, 3'b000, 5'd8, OPI);
    imem[8]  = j_t(20'd8, 5'd1);
    imem[9]  = i_t(12'd77, 5'd0, 3'b000, 5'd1, OPI);
    imem[12] = s_t(12'd16, 5'd1, 5'd0, 3'b010);
    imem[13] = r_t(7'd0, 5'd8, 5'd7, 3'b010, 5'd6);
    imem[14] = s_t(12'd20, 5'd6, 5'd0, 3'b010);
    imem[15] = i_t(12'd26, 5'd0, 3'b000, 5'd9, OPL);
    imem[16] = s_t(12'd24, 5'd9, 5'd0, 3'b010);
    imem[17] = i_t(12'h1AB, 5'd0, 3'b000, 5'd5, OPI);
    imem[18] = s_t(12'd29, 5'd5, 5'd0, 3'b000);
    imem[19] = i_t(12'd7, 5'd0, 3'b000, 5'd10, OPI);
    imem[20] = b_t(12'd4, 5'd0, 5'd0);
    imem[21] = i_t(12'd99, 5'd0, 3'b000, 5'd10, OPI);
    imem[22] = s_t(12'd32, 5'd10, 5'd0, 3'b010);
    imem[23] = s_t(12'd36, 5'd7, 5'd0, 3'b010);
    imem[24] = i_t(12'd36, 5'd0, 3'b010, 5'd12, OPL);
    imem[25] = b_t(12'd4, 5'd7, 5'd12);
    imem[26] = i_t(12'd0, 5'd0, 3'b000, 5'd7, OPI);
    imem[27] = s_t(12'd40, 5'd7, 5'd0, 3'b010);
    imem[28] = j_t(20'd0, 5'd0);
    sb_q.push_back('{32'd0,  32'd8,         1'b0});
    sb_q.push_back('{32'd8,  32'h0000_2468, 1'b0});
    sb_q.push_back('{32'd16, 32'h0000_0024, 1'b0});
    sb_q.push_back('{32'd20, 32'd1,         1'b0});
    sb_q.push_back('{32'd24, 32'hFFFF_FF80, 1'b0});
    sb_q.push_back('{32'd29, 32'hABAB_ABAB, 1'b1});
    sb_q.push_back('{32'd32, 32'd7,         1'b0});
    sb_q.push_back('{32'd36, 32'hFFFF_FFFF, 1'b0});
    sb_q.push_back('{32'd40, 32'hFFFF_FFFF, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_membyte", {31'd0, MemByte}, 32'd0);
    check("rst_aluout", ALUOut, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    reset = 1'b0;

    exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h14, 32'h18, 32'h1C};
    exp_en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check($sformatf("pc_c%0d", k), pc, exp_pc[k]);
      check($sformatf("pc_en_c%0d", k), {31'd0, pc_en}, {31'd0, exp_en[k]});
    end

    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge clk); #1;
      if (MemWrite === 1'b1 && ALUOut === 32'd36) found = 1'b1;
    end
    check("miss_store_seen", {31'd0, found}, 32'd1);
    if (found) begin
      dhit = 1'b0;
      snap_pc = pc; snap_a = ALUOut; snap_d = WriteData;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check("miss_pc", pc, snap_pc);
        check("miss_aluout", ALUOut, snap_a);
        check("miss_wdata", WriteData, snap_d);
        check("miss_memwrite", {31'd0, MemWrite}, 32'd1);
        check("miss_pc_en", {31'd0, pc_en}, 32'd0);
      end
      dhit = 1'b1;
    end

    for (int c = 0; c < 300 && sb_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("stores_left", sb_q.size(), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("final_loop_pc", {pc[31:3], 3'b000}, 32'h70);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
